fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter FETCH_BYTES, 8, bytes returned per memory response (power of two, 8..16).
REQ-002 SHALL have parameter QDEPTH, 32, byte capacity of prefetch queue (power of two, >= 2*FETCH_BYTES).
REQ-003 SHALL have parameter RESET_PC, 64'h0, fetch address after reset.
REQ-004 SHALL have ports as follows; one clock (clk); reset is asynchronous and active-high (reset):
  clk  in  1  clock, all state on rising edge
  reset  in  1  asynchronous active-high reset
  redirect_valid  in  1  flush queue, restart fetch
  redirect_pc  in  64  restart address
  mem_req_valid  out  1  fetch request
  mem_req_ready  in  1  memory accepts request
  mem_req_addr  out  64  fetch address
  mem_resp_valid  in  1  response present (always accepted)
  mem_resp_data  in  8*FETCH_BYTES  bytes, byte 0 at [7:0]
  mem_resp_err  in  1  address error for whole response
  out_valid  out  1  decoded instruction available
  out_ready  in  1  decode stage accepts
  out_pc / out_valP / out_valC  out  64 each  instruction address, next sequential PC, constant
  out_icode / out_ifun / out_rA / out_rB  out  4 each  fields
  out_stat  out  3  1 AOK, 2 HLT, 3 ADR, 4 INS

Function
REQ-005 SHALL decode head byte b0: icode=b0[3:0], ifun=b0[7:4]; b1: rA=b1[3:0], rB=b1[7:4]; valC little-endian 8 bytes after b0 (no regs) or b1 (regs).
REQ-006 SHALL set need_reg for icode 2,3,4,5,6,A,B; need_valC for 3,4,5,7,8; length = 1+need_reg+8*need_valC; valP = pc+length; rA/rB/valC = 0 when not needed.
REQ-007 SHALL assert out_valid only when queue holds >= length bytes of head instruction, or head is HLT/INS/ADR case; fields combinational from queue head; transfer on out_valid&&out_ready pops length bytes.
REQ-008 SHALL report icode>4'hB as stat=4 with length 1; icode 0 as stat=2.
REQ-009 SHALL report stat=3 with icode=1, ifun=0 when any byte the head instruction needs carries the error flag.
REQ-010 SHALL use FSM FETCH (may request), WAIT (one request outstanding), STOP (no requests).
REQ-011 FETCH->WAIT when mem_req_valid&&mem_req_ready; mem_req_valid = FETCH && free space >= FETCH_BYTES; fetch address advances by FETCH_BYTES per accepted request.
REQ-012 WAIT->FETCH on mem_resp_valid; response bytes appended with per-byte error flag = mem_resp_err; data usable at out_* the following cycle.
REQ-013 SHALL enter STOP when a stat 2/3/4 instruction is transferred; STOP exits only on redirect.
REQ-014 redirect_valid from any state: empty queue, fetch address=redirect_pc, state FETCH; if WAIT, the outstanding response SHALL be discarded.
REQ-015 out_valid SHALL be 0 while redirect_valid=1; redirect wins over a simultaneous response or pop.
REQ-016 Queue full: no request issued; outputs hold stable while out_ready=0.
REQ-017 Pointer arithmetic wraps modulo QDEPTH; occupancy counter width clog2(QDEPTH)+1.

Reset
REQ-018 reset SHALL force state FETCH, queue empty, fetch address=RESET_PC, discard flag 0, mem_req_valid=0 until first clk edge after deassertion, out_valid=0, all out_* fields 0.
REQ-019 reset mid-WAIT SHALL ignore any later response belonging to the pre-reset request.

Configuration
REQ-020 With FETCH_PREDICT_EN defined, transfer of icode 7 or 8 SHALL flush younger queue bytes and restart fetch at valC (internal redirect, outstanding response discarded).
REQ-021 Without FETCH_PREDICT_EN, fetch SHALL continue sequentially; all control flow via redirect_valid.

Structure
REQ-022 Shared package y86_fetch_pkg SHALL hold icode constants, stat codes (AOK/HLT/ADR/INS), FSM state enum, length function.
REQ-023 Sub-module insn_len_decode SHALL implement REQ-006/REQ-008 (icode -> need_reg, need_valC, length, invalid).

Verification
REQ-024 RESET_PC=0, mem bytes 03 2F 10 00 00 00 00 00 00 00 -> out icode=3 rA=F rB=2 valC=0x10 valP=0x0A stat=1.
REQ-025 Byte 07 at 0x0, valC=0x40 -> next out_pc=0x40 with FETCH_PREDICT_EN, 0x09 without.
REQ-026 Byte 0C at pc 0x20 -> stat=4, state STOP, no mem_req_valid until redirect.
REQ-027 10-byte instruction at 0x6 straddling 8-byte chunk, second response mem_resp_err=1 -> stat=3 icode=1 ifun=0.
REQ-028 redirect_pc=0x100 during WAIT -> stale response dropped, next mem_req_addr=0x100, next out_pc=0x100.
REQ-029 out_ready=0 for 5 cycles with queue full -> no new request, out_* unchanged.

Source files
------------

// File: rtl/y86_fetch_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes, FSM states
// and the instruction-length helpers used by the fetch queue and its decoder.
package y86_fetch_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  // Longest instruction: opcode + register byte + 8-byte constant.
  localparam int MAX_LEN = 10;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_STOP  = 2'd2
  } fq_state_e;

  function automatic logic insn_need_reg(input logic [3:0] ic);
    return ic inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
  endfunction

  function automatic logic insn_need_valc(input logic [3:0] ic);
    return ic inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
  endfunction

  // Invalid codes fall through both predicates, so they come out as length 1.
  function automatic logic [3:0] insn_len(input logic [3:0] ic);
    return 4'd1 + {3'd0, insn_need_reg(ic)} + (insn_need_valc(ic) ? 4'd8 : 4'd0);
  endfunction

endpackage

// File: rtl/insn_len_decode.sv
// Opcode classifier: register/constant needs, total byte length and invalid flag.
module insn_len_decode
  import y86_fetch_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic       need_reg_o,
  output logic       need_valc_o,
  output logic [3:0] len_o,
  output logic       invalid_o
);

  assign invalid_o   = (icode_i > I_POPQ);
  assign need_reg_o  = insn_need_reg(icode_i);
  assign need_valc_o = insn_need_valc(icode_i);
  assign len_o       = insn_len(icode_i);

endmodule

// File: rtl/fetch_queue.sv
// Y86-64 prefetch byte queue with head-of-queue instruction decode.
// Define FETCH_PREDICT_EN to redirect fetch to the target of jXX/call on transfer.
module fetch_queue
  import y86_fetch_pkg::*;
#(
  parameter int          FETCH_BYTES = 8,
  parameter int          QDEPTH      = 32,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [63:0]              redirect_pc,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [63:0]              mem_req_addr,
  input  logic                     mem_resp_valid,
  input  logic [8*FETCH_BYTES-1:0] mem_resp_data,
  input  logic                     mem_resp_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_pc,
  output logic [63:0]              out_valP,
  output logic [63:0]              out_valC,
  output logic [3:0]               out_icode,
  output logic [3:0]               out_ifun,
  output logic [3:0]               out_rA,
  output logic [3:0]               out_rB,
  output logic [2:0]               out_stat
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  fq_state_e       state_q, state_d;
  logic [PW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [63:0]     pc_q, pc_d, fpc_q, fpc_d;
  logic            discard_q, discard_d;
  logic            started_q;

  logic [7:0]      qbyte_q [QDEPTH];
  logic            qerr_q  [QDEPTH];

  logic [7:0]      hb [MAX_LEN];
  logic            he [MAX_LEN];
  logic            need_reg, need_valc, invalid, adr, head_ok;
  logic [3:0]      len;
  logic [63:0]     valc;
  logic            xfer, stop_take, pred_take, flush, push, req_fire;

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      hb[i] = qbyte_q[rd_q + PW'(i)];
      he[i] = qerr_q[rd_q + PW'(i)];
    end
  end

  insn_len_decode u_dec (
    .icode_i     (hb[0][3:0]),
    .need_reg_o  (need_reg),
    .need_valc_o (need_valc),
    .len_o       (len),
    .invalid_o   (invalid)
  );

  // Address fault: any byte this instruction needs that has already arrived is flagged.
  always_comb begin
    adr = 1'b0;
    for (int i = 0; i < MAX_LEN; i++)
      if ((4'(i) < len) && (CW'(i) < count_q) && he[i]) adr = 1'b1;
    for (int j = 0; j < 8; j++)
      valc[8*j +: 8] = need_reg ? hb[j+2] : hb[j+1];
  end

  assign head_ok   = (count_q >= CW'(len));
  assign out_valid = !redirect_valid && (count_q != '0) && (head_ok || adr);

  always_comb begin
    out_pc    = '0;
    out_valP  = '0;
    out_valC  = '0;
    out_icode = '0;
    out_ifun  = '0;
    out_rA    = '0;
    out_rB    = '0;
    out_stat  = '0;
    if (out_valid) begin
      out_pc   = pc_q;
      out_valP = pc_q + 64'(len);
      if (adr) begin
        out_icode = I_NOP;
        out_stat  = STAT_ADR;
      end else begin
        out_icode = hb[0][3:0];
        out_ifun  = hb[0][7:4];
        out_rA    = need_reg  ? hb[1][3:0] : 4'h0;
        out_rB    = need_reg  ? hb[1][7:4] : 4'h0;
        out_valC  = need_valc ? valc : 64'h0;
        out_stat  = invalid ? STAT_INS : (hb[0][3:0] == I_HALT) ? STAT_HLT : STAT_AOK;
      end
    end
  end

  assign xfer      = out_valid && out_ready;
  assign stop_take = xfer && (out_stat != STAT_AOK);
`ifdef FETCH_PREDICT_EN
  assign pred_take = xfer && (out_stat == STAT_AOK) && (out_icode == I_JXX || out_icode == I_CALL);
`else
  assign pred_take = 1'b0;
`endif
  assign flush = redirect_valid || stop_take || pred_take;

  // New requests wait until a response orphaned by a flush has drained.
  assign mem_req_valid = started_q && (state_q == S_FETCH) && !discard_q &&
                         ((CW'(QDEPTH) - count_q) >= CW'(FETCH_BYTES));
  assign mem_req_addr  = fpc_q;
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign push          = (state_q == S_WAIT) && mem_resp_valid && !flush;

  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    pc_d      = pc_q;
    fpc_d     = fpc_q;
    discard_d = discard_q && !mem_resp_valid;
    if (flush && (((state_q == S_WAIT) && !mem_resp_valid) || req_fire)) discard_d = 1'b1;
    if (req_fire) fpc_d = fpc_q + 64'(FETCH_BYTES);
    case (state_q)
      S_FETCH: if (req_fire) state_d = S_WAIT;
      S_WAIT:  if (mem_resp_valid) state_d = S_FETCH;
      default: state_d = state_q;
    endcase
    if (xfer) begin
      rd_d = rd_q + PW'(len);
      pc_d = pc_q + 64'(len);
    end
    if (push) wr_d = wr_q + PW'(FETCH_BYTES);
    count_d = count_q - (xfer ? CW'(len) : '0) + (push ? CW'(FETCH_BYTES) : '0);
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end
    if (stop_take) state_d = S_STOP;
    if (pred_take) begin
      state_d = S_FETCH;
      fpc_d   = out_valC;
      pc_d    = out_valC;
    end
    if (redirect_valid) begin
      state_d = S_FETCH;
      fpc_d   = redirect_pc;
      pc_d    = redirect_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      rd_q      <= '0;
      wr_q      <= '0;
      count_q   <= '0;
      pc_q      <= RESET_PC;
      fpc_q     <= RESET_PC;
      discard_q <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      pc_q      <= pc_d;
      fpc_q     <= fpc_d;
      discard_q <= discard_d;
      started_q <= 1'b1;
    end
  end

  // Storage needs no reset: bytes are only observed below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        qbyte_q[wr_q + PW'(i)] <= mem_resp_data[8*i +: 8];
        qerr_q[wr_q + PW'(i)]  <= mem_resp_err;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue; expectations are hand-computed per step.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid, mem_resp_err;
  logic [63:0] mem_resp_data;
  logic        out_valid, out_ready;
  logic [63:0] out_pc, out_valP, out_valC;
  logic [3:0]  out_icode, out_ifun, out_rA, out_rB;
  logic [2:0]  out_stat;

  logic [7:0]  mem [0:2047];
  int          checks = 0;
  int          errors = 0;

  fetch_queue dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_valP(out_valP), .out_valC(out_valC),
    .out_icode(out_icode), .out_ifun(out_ifun), .out_rA(out_rA), .out_rB(out_rB),
    .out_stat(out_stat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [63:0] a);
    int n = 0;
    while (!mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_valid", mem_req_valid, 1);
    chk("req_addr", mem_req_addr, a);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [63:0] a, input logic e);
    for (int i = 0; i < 8; i++) mem_resp_data[8*i +: 8] = mem[(int'(a[31:0]) + i) & 2047];
    mem_resp_err   = e;
    mem_resp_valid = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_err   = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic redirect(input logic [63:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    #1 chk("valid_during_redirect", out_valid, 0);
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h01;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_err = 1'b0; mem_resp_data = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_stat", out_stat, 0);
    reset = 1'b0;
    #1 chk("rst_release_req_valid", mem_req_valid, 0);
    @(negedge clk);

    // irmovq $0x10, %r15-style encoding across two chunks
    mem[0] = 8'h03; mem[1] = 8'h2F; mem[2] = 8'h10;
    for (int i = 3; i < 10; i++) mem[i] = 8'h00;
    accept(64'h0); respond(64'h0, 1'b0);
    chk("partial_not_valid", out_valid, 0);
    accept(64'h8); respond(64'h8, 1'b0);
    chk("irm_valid", out_valid, 1);
    chk("irm_icode", out_icode, 4'h3);
    chk("irm_ifun", out_ifun, 4'h0);
    chk("irm_rA", out_rA, 4'hF);
    chk("irm_rB", out_rB, 4'h2);
    chk("irm_valC", out_valC, 64'h10);
    chk("irm_valP", out_valP, 64'h0A);
    chk("irm_stat", out_stat, 3'd1);
    pop();
    chk("nop_pc", out_pc, 64'h0A);
    chk("nop_icode", out_icode, 4'h1);
    chk("nop_valP", out_valP, 64'h0B);
    chk("nop_valC", out_valC, 64'h0);

    // Invalid opcode -> INS, then STOP
    mem[32] = 8'h0C;
    redirect(64'h20);
    accept(64'h20); respond(64'h20, 1'b0);
    chk("ins_valid", out_valid, 1);
    chk("ins_stat", out_stat, 3'd4);
    chk("ins_icode", out_icode, 4'hC);
    chk("ins_valP", out_valP, 64'h21);
    pop();
    for (int k = 0; k < 5; k++) begin
      chk("stop_req_valid", mem_req_valid, 0);
      chk("stop_out_valid", out_valid, 0);
      @(negedge clk);
    end

    // jmp 0x40 at address 0
    mem[0] = 8'h07; mem[1] = 8'h40;
    for (int i = 2; i < 9; i++) mem[i] = 8'h00;
    mem[9] = 8'h01;
    redirect(64'h0);
    accept(64'h0); respond(64'h0, 1'b0);
    chk("jmp_partial", out_valid, 0);
    accept(64'h8); respond(64'h8, 1'b0);
    chk("jmp_icode", out_icode, 4'h7);
    chk("jmp_valC", out_valC, 64'h40);
    chk("jmp_valP", out_valP, 64'h09);
    pop();
`ifdef FETCH_PREDICT_EN
    accept(64'h40); respond(64'h40, 1'b0);
    chk("after_jmp_pc", out_pc, 64'h40);
`else
    chk("after_jmp_pc", out_pc, 64'h09);
`endif
    chk("after_jmp_icode", out_icode, 4'h1);

    // 10-byte instruction whose tail falls in an erroring response
    mem[6] = 8'h03; mem[7] = 8'hF0;
    redirect(64'h6);
    accept(64'h6); respond(64'h6, 1'b0);
    chk("adr_partial", out_valid, 0);
    accept(64'hE); respond(64'hE, 1'b1);
    chk("adr_valid", out_valid, 1);
    chk("adr_stat", out_stat, 3'd3);
    chk("adr_icode", out_icode, 4'h1);
    chk("adr_ifun", out_ifun, 4'h0);
    pop();
    chk("adr_stop_req", mem_req_valid, 0);

    // Redirect while a request is outstanding
    for (int i = 0; i < 8; i++) mem[512 + i] = 8'h0C;
    redirect(64'h200);
    accept(64'h200);
    redirect(64'h100);
    chk("discard_req_blocked", mem_req_valid, 0);
    chk("discard_addr", mem_req_addr, 64'h100);
    respond(64'h200, 1'b0);
    chk("stale_dropped", out_valid, 0);
    accept(64'h100); respond(64'h100, 1'b0);
    chk("redir_pc", out_pc, 64'h100);
    chk("redir_icode", out_icode, 4'h1);

    // Fill the queue with decode stalled
    redirect(64'h300);
    for (int c = 0; c < 4; c++) begin
      accept(64'h300 + 64'(8 * c));
      respond(64'h300 + 64'(8 * c), 1'b0);
    end
    for (int k = 0; k < 5; k++) begin
      chk("full_req_valid", mem_req_valid, 0);
      chk("full_out_valid", out_valid, 1);
      chk("full_out_pc", out_pc, 64'h300);
      chk("full_out_valP", out_valP, 64'h301);
      @(negedge clk);
    end
    pop();
    chk("full_pop_pc", out_pc, 64'h301);
    chk("full_pop_req", mem_req_valid, 0);

    // Reset while waiting: the late response must be ignored
    mem[0] = 8'h00;
    for (int i = 0; i < 8; i++) mem[1024 + i] = 8'h0C;
    redirect(64'h400);
    accept(64'h400);
    reset = 1'b1;
    #1 chk("midrst_req_valid", mem_req_valid, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    respond(64'h400, 1'b0);
    chk("midrst_stale_dropped", out_valid, 0);
    accept(64'h0); respond(64'h0, 1'b0);
    chk("hlt_valid", out_valid, 1);
    chk("hlt_stat", out_stat, 3'd2);
    chk("hlt_icode", out_icode, 4'h0);
    chk("hlt_pc", out_pc, 64'h0);
    chk("hlt_valP", out_valP, 64'h1);
    pop();
    chk("hlt_stop_req", mem_req_valid, 0);
    chk("hlt_stop_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
